// File: rtl/video_writer_pkg.sv
// Shared types and constants for the video memory command writer.
// Cell word = {attribute byte, character index byte}.
package video_writer_pkg;

  localparam int TEXTCOLS_CHAR = 80;
  localparam int TEXTROWS_CHAR = 30;
  localparam int TEXTCOLS_W    = 7;
  localparam int TEXTROWS_W    = 5;
  localparam int ADDR_W        = 16;

  localparam logic [7:0] CTRL_BS    = 8'h08;
  localparam logic [7:0] CTRL_LF    = 8'h0A;
  localparam logic [7:0] CTRL_FF    = 8'h0C;
  localparam logic [7:0] CTRL_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] index;
  } charattr_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Attribute word with its character index field replaced by ch.
  function automatic charattr_t make_cell(input charattr_t a, input logic [7:0] ch);
    charattr_t c;
    c       = a;
    c.index = ch;
    return c;
  endfunction

endpackage

// File: rtl/video_writer_if.sv
// Byte command handshake plus masked video memory write port.
// slave = writer side, master = byte source / memory side.
interface video_writer_if;
  import video_writer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_byte;
  logic              video_write;
  logic [ADDR_W-1:0] video_address;
  charattr_t         video_value;
  charattr_t         video_mask;

  modport master (
    output cmd_valid, cmd_byte,
    input  cmd_ready, video_write, video_address, video_value, video_mask
  );

  modport slave (
    input  cmd_valid, cmd_byte,
    output cmd_ready, video_write, video_address, video_value, video_mask
  );
endinterface

// File: rtl/video_writer_text_cursor.sv
// Text cursor: x/y position with wrap and backspace saturation, plus an
// incrementally maintained row base so the cell address needs no multiplier.
module text_cursor
  import video_writer_pkg::*;
#(
  parameter int COLS = TEXTCOLS_CHAR,
  parameter int ROWS = TEXTROWS_CHAR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  newline,
  input  logic                  carriage_return,
  input  logic                  backspace,
  input  logic                  home,
  output logic [TEXTCOLS_W-1:0] x,
  output logic [TEXTROWS_W-1:0] y,
  output logic [ADDR_W-1:0]     addr
);

  logic [TEXTCOLS_W-1:0] x_q, x_d;
  logic [TEXTROWS_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0]     row_base_q, row_base_d;
  logic                  row_adv;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    row_adv    = 1'b0;
    if (home) begin
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
    end else begin
      if (advance) begin
        if (x_q == TEXTCOLS_W'(COLS - 1)) begin
          x_d     = '0;
          row_adv = 1'b1;
        end else begin
          x_d = x_q + TEXTCOLS_W'(1);
        end
      end
      if (carriage_return) x_d = '0;
      if (backspace && (x_q != '0)) x_d = x_q - TEXTCOLS_W'(1);
      if (newline) row_adv = 1'b1;
      // No scrolling: the bottom row wraps back to the top.
      if (row_adv) begin
        if (y_q == TEXTROWS_W'(ROWS - 1)) begin
          y_d        = '0;
          row_base_d = '0;
        end else begin
          y_d        = y_q + TEXTROWS_W'(1);
          row_base_d = row_base_q + ADDR_W'(COLS);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign addr = row_base_q + ADDR_W'(x_q);

endmodule

// File: rtl/video_writer.sv
// Byte-stream front end for the video memory write port: printable bytes
// become cell writes at the cursor, control codes move it, FF fills the screen.
module video_writer
  import video_writer_pkg::*;
#(
  parameter int COLS = TEXTCOLS_CHAR,
  parameter int ROWS = TEXTROWS_CHAR
) (
  input  logic                  clk,
  input  logic                  reset,
  video_writer_if.slave         bus,
  input  logic                  set_attr,
  input  charattr_t             attr_value,
  output logic [TEXTCOLS_W-1:0] cursor_x,
  output logic [TEXTROWS_W-1:0] cursor_y
);

  localparam int TOTAL = COLS * ROWS;
  localparam int CNT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  charattr_t         attr_q, attr_d, attr_eff;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  charattr_t         value_q, value_d;
  charattr_t         mask_q, mask_d;
  logic [ADDR_W-1:0] cur_addr;
  logic              advance, newline, carriage_return, backspace, home;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk             (clk),
    .reset           (reset),
    .advance         (advance),
    .newline         (newline),
    .carriage_return (carriage_return),
    .backspace       (backspace),
    .home            (home),
    .x               (cursor_x),
    .y               (cursor_y),
    .addr            (cur_addr)
  );

  always_comb begin
    state_d         = state_q;
    fill_d          = fill_q;
    wr_d            = 1'b0;
    addr_d          = addr_q;
    value_d         = value_q;
    mask_d          = mask_q;
    advance         = 1'b0;
    newline         = 1'b0;
    carriage_return = 1'b0;
    backspace       = 1'b0;
    home            = 1'b0;
    // A same-cycle set_attr already applies to the word issued this cycle.
    attr_eff        = set_attr ? attr_value : attr_q;
    attr_d          = attr_eff;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_byte >= CHAR_SPACE) begin
            wr_d    = 1'b1;
            addr_d  = cur_addr;
            value_d = make_cell(attr_eff, bus.cmd_byte);
            mask_d  = '1;
            advance = 1'b1;
          end else begin
            case (bus.cmd_byte)
              CTRL_CR: carriage_return = 1'b1;
              CTRL_LF: newline         = 1'b1;
              CTRL_BS: backspace       = 1'b1;
              CTRL_FF: begin
                // First fill word is issued on acceptance so it lands at N+1.
                state_d = ST_CLEAR;
                wr_d    = 1'b1;
                addr_d  = '0;
                value_d = make_cell(attr_eff, CHAR_SPACE);
                mask_d  = '1;
                fill_d  = CNT_W'(1);
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        if (fill_q == CNT_W'(TOTAL)) begin
          state_d = ST_IDLE;
          home    = 1'b1;
        end else begin
          wr_d    = 1'b1;
          addr_d  = fill_q[ADDR_W-1:0];
          value_d = make_cell(attr_eff, CHAR_SPACE);
          mask_d  = '1;
          fill_d  = fill_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      attr_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      attr_q  <= attr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.cmd_ready     = (state_q == ST_IDLE);
  assign bus.video_write   = wr_q;
  assign bus.video_address = addr_q;
  assign bus.video_value   = value_q;
  assign bus.video_mask    = mask_q;

endmodule

// File: tb/tb_video_writer.sv
// Bench for video_writer (4x3 screen): vector table, hand-written clear and
// reset sequences, then random traffic against a cycle-indexed screen model.
module tb_video_writer;
  import video_writer_pkg::*;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int TOTAL = COLS * ROWS;

  logic            clk = 1'b0;
  logic            reset;
  logic            set_attr;
  charattr_t       attr_value;
  logic [TEXTCOLS_W-1:0] cursor_x;
  logic [TEXTROWS_W-1:0] cursor_y;

  video_writer_if bus();

  video_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .set_attr   (set_attr),
    .attr_value (attr_value),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: cursor as integers, clear tracked by the edge index at
  // which FF was taken; fill word k appears after edge ff_e+k.
  int        m_x, m_y, m_last, m_ff_e;
  charattr_t m_attr, m_val, m_mask;
  logic      m_wr;
  logic [15:0] m_addr;

  function automatic bit in_clear(input int l);
    return (m_ff_e >= 0) && (l >= m_ff_e) && (l <= m_ff_e + TOTAL - 1);
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_last = 0; m_ff_e = -1;
    m_attr = '0; m_val = '0; m_mask = '0; m_wr = 1'b0; m_addr = '0;
  endtask

  task automatic model_step(input bit s, input charattr_t av, input bit v, input logic [7:0] b);
    bit busy;
    int e;
    busy = in_clear(m_last);
    if (s) m_attr = av;
    e = m_last + 1;
    m_wr = 1'b0;
    if (!busy && v) begin
      if (b >= 8'h20) begin
        m_wr = 1'b1;
        m_addr = 16'(m_y * COLS + m_x);
        m_val = {m_attr[15:8], b};
        m_mask = 16'hFFFF;
        m_x++;
        if (m_x == COLS) begin m_x = 0; m_y = (m_y + 1) % ROWS; end
      end else if (b == 8'h0D) m_x = 0;
      else if (b == 8'h0A) m_y = (m_y + 1) % ROWS;
      else if (b == 8'h08) begin if (m_x > 0) m_x--; end
      else if (b == 8'h0C) m_ff_e = e;
    end
    if (m_ff_e >= 0 && e >= m_ff_e && e - m_ff_e < TOTAL) begin
      m_wr = 1'b1;
      m_addr = 16'(e - m_ff_e);
      m_val = {m_attr[15:8], 8'h20};
      m_mask = 16'hFFFF;
    end
    if (m_ff_e >= 0 && e == m_ff_e + TOTAL) begin m_x = 0; m_y = 0; end
    m_last = e;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".write"}, 32'(bus.video_write), 32'(m_wr));
    chk({tag, ".addr"},  32'(bus.video_address), 32'(m_addr));
    chk({tag, ".value"}, 32'(bus.video_value), 32'(m_val));
    chk({tag, ".mask"},  32'(bus.video_mask), 32'(m_mask));
    chk({tag, ".x"},     32'(cursor_x), 32'(m_x));
    chk({tag, ".y"},     32'(cursor_y), 32'(m_y));
    chk({tag, ".ready"}, 32'(bus.cmd_ready), 32'(!in_clear(m_last)));
  endtask

  task automatic step(input bit s, input charattr_t av, input bit v, input logic [7:0] b);
    set_attr = s; attr_value = av; bus.cmd_valid = v; bus.cmd_byte = b;
    model_step(s, av, v, b);
    @(posedge clk); #1;
    check_model("step");
    set_attr = 1'b0; bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1 check_model("reset");
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_model("post_reset");
  endtask

  typedef struct {
    bit          rst;
    bit          s;
    charattr_t   av;
    logic [7:0]  b;
    bit          ew;
    logic [15:0] ea;
    logic [7:0]  eidx;
    int          ex;
    int          ey;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit s, input logic [15:0] av, input logic [7:0] b,
                              input bit ew, input int ea, input int ex, input int ey);
    vec_t t;
    t.rst = rst; t.s = s; t.av = av; t.b = b; t.ew = ew;
    t.ea = 16'(ea); t.eidx = b; t.ex = ex; t.ey = ey;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    charattr_t p, q;
    reset = 1'b1; set_attr = 1'b0; attr_value = '0;
    bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00;

    // Single character with full attributes.
    tbl.push_back(mk(1, 1, 16'hFFFF, 8'h41, 1, 0, 1, 0));
    // Thirteen back-to-back printables: addresses 0..11 then 0 again.
    for (int i = 0; i < 13; i++)
      tbl.push_back(mk(i == 0, 0, 16'h0000, 8'(8'h30 + i), 1, i % TOTAL,
                       (i + 1) % COLS, ((i + 1) / COLS) % ROWS));
    // "AB" CR LF BS BS "C".
    tbl.push_back(mk(1, 0, 16'h0, 8'h41, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0, 8'h42, 1, 1, 2, 0));
    tbl.push_back(mk(0, 0, 16'h0, 8'h0D, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0, 8'h0A, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0, 8'h08, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0, 8'h08, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0, 8'h43, 1, 4, 1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].s, tbl[i].av, 1'b1, tbl[i].b);
      chk("tbl.write", 32'(bus.video_write), 32'(tbl[i].ew));
      if (tbl[i].ew) begin
        chk("tbl.addr", 32'(bus.video_address), 32'(tbl[i].ea));
        chk("tbl.index", 32'(bus.video_value.index), 32'(tbl[i].eidx));
      end
      chk("tbl.x", 32'(cursor_x), 32'(tbl[i].ex));
      chk("tbl.y", 32'(cursor_y), 32'(tbl[i].ey));
    end

    // Clear screen; ignored bytes during the fill, attribute change mid-fill.
    p = 16'h5A77;
    q = 16'hC3EE;
    step(1'b0, '0, 1'b1, 8'h51);
    step(1'b1, p, 1'b1, 8'h0C);
    chk("clr.first_addr", 32'(bus.video_address), 32'h0);
    chk("clr.first_value", 32'(bus.video_value), 32'h5A20);
    for (int k = 1; k < TOTAL; k++) begin
      step(k == 6, q, 1'b1, 8'h5A);
      chk("clr.ready", 32'(bus.cmd_ready), 32'h0);
      chk("clr.addr", 32'(bus.video_address), 32'(k));
      chk("clr.attr", 32'(bus.video_value.attr), (k < 6) ? 32'h5A : 32'hC3);
    end
    step(1'b0, '0, 1'b0, 8'h00);
    chk("clr.done_ready", 32'(bus.cmd_ready), 32'h1);
    chk("clr.done_write", 32'(bus.video_write), 32'h0);
    chk("clr.done_x", 32'(cursor_x), 32'h0);
    chk("clr.done_y", 32'(cursor_y), 32'h0);

    // Reset while the fifth fill word is on the port.
    step(1'b0, '0, 1'b1, 8'h61);
    step(1'b1, 16'h1234, 1'b1, 8'h0C);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, 8'h00);
    chk("mid.addr_before", 32'(bus.video_address), 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("mid.write", 32'(bus.video_write), 32'h0);
    chk("mid.addr", 32'(bus.video_address), 32'h0);
    chk("mid.value", 32'(bus.video_value), 32'h0);
    chk("mid.mask", 32'(bus.video_mask), 32'h0);
    chk("mid.ready", 32'(bus.cmd_ready), 32'h1);
    chk("mid.x", 32'(cursor_x), 32'h0);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_model("mid.after");

    // Same-cycle set_attr and printable.
    step(1'b1, 16'h9900, 1'b1, 8'h7E);
    chk("simul.value", 32'(bus.video_value), 32'h997E);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)       b = 8'h0C;
      else if (r < 10) b = 8'h0D;
      else if (r < 18) b = 8'h0A;
      else if (r < 26) b = 8'h08;
      else if (r < 30) b = 8'($urandom_range(0, 31));
      else             b = 8'($urandom_range(32, 255));
      step($urandom_range(0, 7) == 0, charattr_t'(16'($urandom)), $urandom_range(0, 3) != 0, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
